// File: rtl/mc_block_arbiter_if.sv
// Requester-side bundle of the block arbiter: N_REQ request lanes in, one-hot responses out.
interface mc_block_arbiter_if #(
    parameter int N_REQ = 4
);
    // A request transfers in the cycle req_valid_i[i] & req_ready_o[i]; the requester holds
    // valid and payload stable until then. rsp_valid_o is a one-cycle pulse, and rsp_ready_i
    // only gates blk_available, i.e. back-pressure is applied before the controller responds.
    logic [N_REQ-1:0]     req_valid_i;
    logic [N_REQ-1:0]     req_ready_o;
    logic [N_REQ-1:0]     req_read_i;
    logic [N_REQ-1:0]     req_write_i;
    logic [N_REQ*32-1:0]  req_address_i;
    logic [N_REQ*64-1:0]  req_dirty_i;
    logic [N_REQ*512-1:0] req_data_i;
    logic [N_REQ-1:0]     rsp_valid_o;
    logic [31:0]          rsp_address_o;
    logic [511:0]         rsp_data_o;
    logic [N_REQ-1:0]     rsp_ready_i;

    modport slave (
        input  req_valid_i, req_read_i, req_write_i, req_address_i, req_dirty_i, req_data_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_address_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_read_i, req_write_i, req_address_i, req_dirty_i, req_data_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_address_o, rsp_data_o
    );
endinterface

// File: rtl/mc_block_arbiter.sv
// Round-robin arbiter sharing the memory controller block port among N_REQ requesters,
// with an in-order owner FIFO that routes read responses back to the issuing requester.
module mc_block_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    mc_block_arbiter_if.slave rq,
    output logic [31:0]       blk_request_address,
    output logic [63:0]       blk_request_dirty_mask,
    output logic [511:0]      blk_request_data,
    output logic              blk_request_read,
    output logic              blk_request_write,
    input  logic              mc_available,
    input  logic              mc_response_valid,
    input  logic [31:0]       mc_response_address,
    input  logic [511:0]      mc_response_data,
    output logic              blk_available,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    owner_q;
    logic             rd_pulse_q, wr_pulse_q, err_q;
    logic [31:0]      addr_q;
    logic [63:0]      dirty_q;
    logic [511:0]     data_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [31:0]      rsp_addr_q;
    logic [511:0]     rsp_data_q;

    logic [PW-1:0]    fifo_mem_q [ID_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             fifo_full, fifo_empty, push, pop;
    logic [PW-1:0]    head;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] ready;
    logic [PW:0]      rr_idx;
    logic             grant;
    logic [PW-1:0]    win;
    logic             win_rd, win_wr;
    logic [31:0]      win_addr;
    logic [63:0]      win_dirty;
    logic [511:0]     win_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(ID_DEPTH));
    assign head       = fifo_mem_q[rd_ptr_q];
    assign push       = rd_pulse_q;
    assign pop        = mc_response_valid & ~fifo_empty;

    // A pure read cannot be granted while the owner FIFO is full; writes and malformed requests can.
    always_comb begin : eligibility
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = rq.req_valid_i[i] & ~(rq.req_read_i[i] & ~rq.req_write_i[i] & fifo_full);
        end
    end

    always_comb begin : rr_search
        grant  = 1'b0;
        win    = '0;
        rr_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (rr_idx >= (PW+1)'(N_REQ)) rr_idx = rr_idx - (PW+1)'(N_REQ);
            if (!grant && eligible[rr_idx[PW-1:0]]) begin
                grant = 1'b1;
                win   = rr_idx[PW-1:0];
            end
        end
        if (state_q != S_IDLE || !mc_available) grant = 1'b0;
    end

    always_comb begin : winner_mux
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        win_addr  = '0;
        win_dirty = '0;
        win_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                win_rd    = rq.req_read_i[i];
                win_wr    = rq.req_write_i[i];
                win_addr  = rq.req_address_i[i*32 +: 32];
                win_dirty = rq.req_dirty_i[i*64 +: 64];
                win_data  = rq.req_data_i[i*512 +: 512];
            end
        end
    end

    always_comb begin : ready_onehot
        ready = '0;
        if (grant) ready[win] = 1'b1;
    end

    always_comb begin : next_state
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: if (grant) begin
                state_d  = S_ISSUE;
                rr_ptr_d = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
            end
            S_ISSUE: state_d = S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            rd_pulse_q  <= 1'b0;
            wr_pulse_q  <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            dirty_q     <= '0;
            data_q      <= '0;
            rsp_valid_q <= '0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            // Both set issues as a write; neither set is granted and dropped.
            rd_pulse_q <= grant & win_rd & ~win_wr;
            wr_pulse_q <= grant & win_wr;
            if (grant) begin
                owner_q <= win;
                addr_q  <= win_addr;
                dirty_q <= win_dirty;
                data_q  <= win_data;
            end
            if ((grant && (win_rd == win_wr)) || (mc_response_valid && fifo_empty)) err_q <= 1'b1;

            rsp_valid_q <= '0;
            if (pop) begin
                rsp_valid_q[head] <= 1'b1;
                rsp_addr_q        <= mc_response_address;
                rsp_data_q        <= mc_response_data;
                rd_ptr_q          <= rd_ptr_q + AW'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= owner_q;
    end

    assign rq.req_ready_o         = ready;
    assign rq.rsp_valid_o         = rsp_valid_q;
    assign rq.rsp_address_o       = rsp_addr_q;
    assign rq.rsp_data_o          = rsp_data_q;
    assign blk_request_address    = addr_q;
    assign blk_request_dirty_mask = dirty_q;
    assign blk_request_data       = data_q;
    assign blk_request_read       = rd_pulse_q;
    assign blk_request_write      = wr_pulse_q;
    assign blk_available          = ~fifo_empty & rq.rsp_ready_i[head];
    assign err_o                  = err_q;
    assign dbg_state_o            = state_q;
endmodule
